// File: rtl/cmv300_cap_pkg.sv
// Shared definitions for the CMV300 frame capture block: FSM state
// encoding, counter widths and a width helper for parameterised counters.
package cmv300_cap_pkg;

  // FSM state encoding, also exported on the ILA state port
  localparam int STATE_W = 3;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FIFO_RST  = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_WAIT_LINE = 3'd3;
  localparam logic [2:0] ST_CAPTURE   = 3'd4;
  localparam logic [2:0] ST_FRAME_END = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  // Counter and data widths
  localparam int PIX_CNT_W   = 10;
  localparam int LINE_CNT_W  = 10;
  localparam int FRAME_CNT_W = 16;
  localparam int PIX_W       = 8;

  // Bits needed to hold the value max_val itself (never less than 1)
  function automatic int cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cap_watchdog.sv
// Line-activity watchdog: counts enabled cycles since the last clear and
// raises expire_o on the cycle the count reaches TIMEOUT-1, so the caller's
// registered reaction lands exactly TIMEOUT cycles after the clear.
module cap_watchdog
  import cmv300_cap_pkg::*;
#(
  parameter int unsigned TIMEOUT = 2**20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A clear wins over expiry so any lval edge resets the window
  assign expire_o = en_i & ~clr_i & (cnt_q == LAST);

  // Next count: clear, else count while enabled, holding at the last value
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cmv300_frame_capture.sv
// CMV300 frame capture: requests frames from the sensor, qualifies pixels
// with lval/dval and writes one byte per pixel into the capture FIFO,
// repeating for the host-programmed number of frames.
// Optional build macro CAPTURE_TEST_PATTERN_EN replaces the pixel byte with
// pixel_cnt[7:0] ^ line_cnt[7:0] while still following sensor timing.
module cmv300_frame_capture
  import cmv300_cap_pkg::*;
#(
  parameter int unsigned PIX_PER_LINE  = 648,
  parameter int unsigned LINES_PER_FRM = 488,
  parameter int unsigned REQ_CYCLES    = 4,
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned TIMEOUT       = 2**20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [FRAME_CNT_W-1:0] num_frames,
  input  logic                   lval,
  input  logic                   dval,
  input  logic [PIX_W-1:0]       pix_data,
  input  logic                   fifo_full,
  output logic                   frame_req,
  output logic                   wr_rst,
  output logic                   wr_en,
  output logic [PIX_W-1:0]       wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic                   timeout,
  output logic [PIX_CNT_W-1:0]   pixel_cnt,
  output logic [LINE_CNT_W-1:0]  line_cnt,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [STATE_W-1:0]     state
);

  localparam int unsigned PHASE_MAX = (RST_CYCLES > REQ_CYCLES) ? RST_CYCLES : REQ_CYCLES;
  localparam int PHASE_W   = cnt_width(PHASE_MAX);
  localparam int FRM_NXT_W = FRAME_CNT_W + 1;
  localparam logic [PHASE_W-1:0]    RST_LAST  = PHASE_W'(RST_CYCLES - 1);
  localparam logic [PHASE_W-1:0]    REQ_LAST  = PHASE_W'(REQ_CYCLES - 1);
  localparam logic [PIX_CNT_W-1:0]  PIX_MAX   = PIX_CNT_W'(PIX_PER_LINE);
  localparam logic [LINE_CNT_W-1:0] LINE_LAST = LINE_CNT_W'(LINES_PER_FRM - 1);

  // Pixel index advances per sample but sticks at PIX_PER_LINE on long lines
  function automatic logic [PIX_CNT_W-1:0] pix_sat_inc(input logic [PIX_CNT_W-1:0] cnt);
    return (cnt < PIX_MAX) ? cnt + PIX_CNT_W'(1) : cnt;
  endfunction

  logic [STATE_W-1:0]     state_q, state_d;
  logic [PHASE_W-1:0]     phase_q, phase_d;
  logic [FRAME_CNT_W-1:0] nfr_q, nfr_d;
  logic [PIX_CNT_W-1:0]   pixel_cnt_q, pixel_cnt_d;
  logic [LINE_CNT_W-1:0]  line_cnt_q, line_cnt_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   wr_en_q, wr_en_d;
  logic [PIX_W-1:0]       wr_data_q, wr_data_d;
  logic                   overflow_q, overflow_d;
  logic                   timeout_q, timeout_d;
  logic                   lval_q;
  logic                   wr_rst_q, frame_req_q, busy_q, done_q;

  logic                   in_window;
  logic                   sample;
  logic                   lval_edge;
  logic                   line_end;
  logic                   wd_clr;
  logic                   wd_expire;
  logic [FRM_NXT_W-1:0]   frame_next;

  // Capture window covers WAIT_LINE too so a line already high on entry
  // loses no pixels.
  assign in_window  = (state_q == ST_WAIT_LINE) || (state_q == ST_CAPTURE);
  assign sample     = in_window & lval & dval;
  assign lval_edge  = lval ^ lval_q;
  assign line_end   = (state_q == ST_CAPTURE) & lval_q & ~lval;
  assign frame_next = {1'b0, frame_cnt_q} + FRM_NXT_W'(1);

  // The watchdog is held clear through REQ so it starts from zero on
  // WAIT_LINE entry; within a frame every lval edge restarts it.
  assign wd_clr = lval_edge | (state_q == ST_REQ);

  cap_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (in_window),
    .clr_i    (wd_clr),
    .expire_o (wd_expire)
  );

`ifdef CAPTURE_TEST_PATTERN_EN
  logic unused_pix;
  assign unused_pix = ^pix_data;
`endif

  // Next-state logic: pixel qualification followed by the frame sequencer
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    nfr_d       = nfr_q;
    pixel_cnt_d = pixel_cnt_q;
    line_cnt_d  = line_cnt_q;
    frame_cnt_d = frame_cnt_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    overflow_d  = overflow_q;
    timeout_d   = timeout_q;

    if (sample) begin
      pixel_cnt_d = pix_sat_inc(pixel_cnt_q);
      if (fifo_full) begin
        overflow_d = 1'b1;
      end else if (pixel_cnt_q < PIX_MAX) begin
        wr_en_d = 1'b1;
`ifdef CAPTURE_TEST_PATTERN_EN
        wr_data_d = pixel_cnt_q[7:0] ^ line_cnt_q[7:0];
`else
        wr_data_d = pix_data;
`endif
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_FIFO_RST;
          phase_d     = '0;
          nfr_d       = (num_frames == '0) ? FRAME_CNT_W'(1) : num_frames;
          pixel_cnt_d = '0;
          line_cnt_d  = '0;
          frame_cnt_d = '0;
          overflow_d  = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      ST_FIFO_RST: begin
        if (phase_q == RST_LAST) begin
          state_d = ST_REQ;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      ST_REQ: begin
        if (phase_q == REQ_LAST) begin
          state_d = ST_WAIT_LINE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      ST_WAIT_LINE: begin
        if (wd_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else if (lval) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (wd_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else if (line_end) begin
          pixel_cnt_d = '0;
          line_cnt_d  = line_cnt_q + LINE_CNT_W'(1);
          state_d     = (line_cnt_q == LINE_LAST) ? ST_FRAME_END : ST_WAIT_LINE;
        end
      end
      ST_FRAME_END: begin
        frame_cnt_d = frame_next[FRAME_CNT_W-1:0];
        if (frame_next >= {1'b0, nfr_q}) begin
          state_d = ST_DONE;
        end else begin
          // line_cnt keeps its final value at DONE but restarts per frame
          line_cnt_d = '0;
          phase_d    = '0;
          state_d    = ST_REQ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; strobes follow the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      nfr_q       <= '0;
      pixel_cnt_q <= '0;
      line_cnt_q  <= '0;
      frame_cnt_q <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      lval_q      <= 1'b0;
      wr_rst_q    <= 1'b0;
      frame_req_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      nfr_q       <= nfr_d;
      pixel_cnt_q <= pixel_cnt_d;
      line_cnt_q  <= line_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
      lval_q      <= lval;
      wr_rst_q    <= (state_d == ST_FIFO_RST);
      frame_req_q <= (state_d == ST_REQ);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
    end
  end

  assign frame_req = frame_req_q;
  assign wr_rst    = wr_rst_q;
  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign timeout   = timeout_q;
  assign pixel_cnt = pixel_cnt_q;
  assign line_cnt  = line_cnt_q;
  assign frame_cnt = frame_cnt_q;
  assign state     = state_q;

endmodule
